// File: rtl/microseq_pkg.sv
// Shared types and microword layout helpers for the microsequencer.
// Microword, MSB first: {cw, mode, addr, cond_sel, cond_inv}.
package microseq_pkg;

  typedef enum logic [2:0] {
    MODE_INC    = 3'd0,
    MODE_JUMP   = 3'd1,
    MODE_DECODE = 3'd2,
    MODE_COND   = 3'd3,
    MODE_CALL   = 3'd4,
    MODE_RET    = 3'd5,
    MODE_FETCH  = 3'd6,
    MODE_RSVD   = 3'd7
  } mode_e;

  localparam int MODE_W      = 3;
  localparam int FETCH_STATE = 0;

  function automatic int f_csel_bits(int num_cond);
    return (num_cond > 1) ? $clog2(num_cond) : 1;
  endfunction

  function automatic int f_inv_lsb();
    return 0;
  endfunction

  function automatic int f_csel_lsb();
    return 1;
  endfunction

  function automatic int f_addr_lsb(int csb);
    return 1 + csb;
  endfunction

  function automatic int f_mode_lsb(int sb, int csb);
    return 1 + csb + sb;
  endfunction

  function automatic int f_cw_lsb(int sb, int csb);
    return f_mode_lsb(sb, csb) + MODE_W;
  endfunction

  function automatic int f_mw_width(int cw, int sb, int csb);
    return f_cw_lsb(sb, csb) + cw;
  endfunction

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO for the microsequencer; push is ignored when full,
// pop is ignored when empty. Reset empties it.
module microseq_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_top_idx;

  assign w_top_idx = PW'(r_cnt - C_ONE);
  assign o_top     = r_mem[w_top_idx];
  assign o_full    = (r_cnt == C_DEPTH);
  assign o_empty   = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_mem[PW'(r_cnt)] <= i_din;
      r_cnt             <= r_cnt + C_ONE;
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end
endmodule

// File: rtl/microsequencer.sv
// Self-sequencing micro-engine: microstore + decode map + next-state logic.
// Define MICROSEQ_STACK_EN to build the CALL/RET return stack.
module microsequencer
  import microseq_pkg::*;
#(
  parameter int CW_WIDTH    = 34,
  parameter int STATE_BITS  = 10,
  parameter int NUM_STATES  = 50,
  parameter int OPC_BITS    = 8,
  parameter int NUM_COND    = 4,
  parameter int STACK_DEPTH = 4,
  localparam int COND_SEL_BITS = f_csel_bits(NUM_COND),
  localparam int MW = f_mw_width(CW_WIDTH, STATE_BITS, COND_SEL_BITS),
  // Microstore and decode-map images, entry 0 in the LSBs.
  parameter logic [NUM_STATES*MW-1:0]              ROM_IMAGE    = '0,
  parameter logic [(2**OPC_BITS)*STATE_BITS-1:0]   DECODE_IMAGE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [OPC_BITS-1:0]   opcode,
  input  logic [NUM_COND-1:0]   cond,
  output logic [CW_WIDTH-1:0]   ctrl_out,
  output logic [STATE_BITS-1:0] state,
  output logic                  err
);
  localparam int N_ADDR   = 2**STATE_BITS;
  localparam int N_OPC    = 2**OPC_BITS;
  localparam int CW_LSB   = f_cw_lsb(STATE_BITS, COND_SEL_BITS);
  localparam int MODE_LSB = f_mode_lsb(STATE_BITS, COND_SEL_BITS);
  localparam int ADDR_LSB = f_addr_lsb(COND_SEL_BITS);
  localparam int CSEL_LSB = f_csel_lsb();
  localparam int INV_LSB  = f_inv_lsb();
  localparam logic [STATE_BITS:0]   LIMIT   = (STATE_BITS+1)'(NUM_STATES);
  localparam logic [STATE_BITS:0]   ONE     = (STATE_BITS+1)'(1);
  localparam logic [STATE_BITS-1:0] S_FETCH = STATE_BITS'(FETCH_STATE);

  if (NUM_STATES > N_ADDR || STACK_DEPTH < 1) begin : g_bad_cfg
    $error("microsequencer: bad configuration");
  end

  logic [STATE_BITS-1:0] r_state;
  logic [CW_WIDTH-1:0]   r_ctrl;
  logic                  r_err;

  logic [CW_WIDTH-1:0]   w_cw  [N_ADDR];
  logic [CW_LSB-1:0]     w_seq [N_ADDR];
  logic [STATE_BITS-1:0] w_dec [N_OPC];

  // Unpopulated addresses read as zero, i.e. a plain INC with an empty control word.
  for (genvar g = 0; g < N_ADDR; g++) begin : g_rom
    if (g < NUM_STATES) begin : g_pop
      assign w_cw[g]  = ROM_IMAGE[g*MW + CW_LSB +: CW_WIDTH];
      assign w_seq[g] = ROM_IMAGE[g*MW +: CW_LSB];
    end else begin : g_zero
      assign w_cw[g]  = '0;
      assign w_seq[g] = '0;
    end
  end

  for (genvar g = 0; g < N_OPC; g++) begin : g_dec
    assign w_dec[g] = DECODE_IMAGE[g*STATE_BITS +: STATE_BITS];
  end

  logic [CW_LSB-1:0]        w_cur;
  mode_e                    w_mode;
  logic [STATE_BITS-1:0]    w_addr;
  logic [COND_SEL_BITS-1:0] w_csel;
  logic                     w_inv;
  logic [STATE_BITS:0]      w_inc;
  logic [STATE_BITS:0]      w_raw;
  logic                     w_over;
  logic                     w_fault;
  logic [STATE_BITS-1:0]    w_next;
  logic [CW_WIDTH-1:0]      w_next_cw;

  assign w_cur  = w_seq[r_state];
  assign w_mode = mode_e'(w_cur[MODE_LSB +: MODE_W]);
  assign w_addr = w_cur[ADDR_LSB +: STATE_BITS];
  assign w_csel = w_cur[CSEL_LSB +: COND_SEL_BITS];
  assign w_inv  = w_cur[INV_LSB];
  assign w_inc  = {1'b0, r_state} + ONE;

`ifdef MICROSEQ_STACK_EN
  logic                  w_push, w_pop, w_full, w_empty;
  logic [STATE_BITS-1:0] w_top;

  microseq_stack #(.DEPTH(STACK_DEPTH), .W(STATE_BITS)) u_stack (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push & ~stall),
    .i_pop   (w_pop & ~stall),
    .i_din   (w_inc[STATE_BITS-1:0]),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= w_cw[S_FETCH];
      r_err   <= 1'b0;
    end else if (!stall) begin
      r_state <= w_next;
      r_ctrl  <= w_next_cw;
      r_err   <= r_err | w_fault;
    end
  end

  // Next state is computed one bit wider so an INC off the top is caught by the range check.
  always_comb begin
    w_raw   = {1'b0, S_FETCH};
    w_fault = 1'b0;
`ifdef MICROSEQ_STACK_EN
    w_push  = 1'b0;
    w_pop   = 1'b0;
`endif
    case (w_mode)
      MODE_INC:    w_raw = w_inc;
      MODE_JUMP:   w_raw = {1'b0, w_addr};
      MODE_DECODE: w_raw = {1'b0, w_dec[opcode]};
      MODE_COND:   w_raw = (cond[w_csel] ^ w_inv) ? {1'b0, w_addr} : w_inc;
      MODE_CALL: begin
        w_raw = {1'b0, w_addr};
`ifdef MICROSEQ_STACK_EN
        if (w_full) w_fault = 1'b1;
        else        w_push  = 1'b1;
`endif
      end
      MODE_RET: begin
        w_raw = {1'b0, S_FETCH};
`ifdef MICROSEQ_STACK_EN
        if (w_empty) begin
          w_fault = 1'b1;
        end else begin
          w_pop = 1'b1;
          w_raw = {1'b0, w_top};
        end
`endif
      end
      MODE_FETCH:  w_raw = {1'b0, S_FETCH};
      default:     w_fault = 1'b1;
    endcase
    w_over = (w_raw >= LIMIT);
    w_next = w_over ? S_FETCH : w_raw[STATE_BITS-1:0];
    if (w_over) w_fault = 1'b1;
  end

  always_comb begin
    w_next_cw = w_cw[w_next];
  end

  assign state    = r_state;
  assign ctrl_out = r_ctrl;
  assign err      = r_err;
endmodule

// File: tb/tb_microsequencer.sv
// Directed + random bench for microsequencer against a queue-based reference model.
module tb_microsequencer;
  localparam int CW = 34, SB = 10, NS = 50, OB = 8, NC = 4, SD = 4;
  localparam int MW = CW + 3 + SB + 2 + 1;

  typedef struct packed {
    logic [2:0]    mode;
    logic [SB-1:0] addr;
    logic [1:0]    sel;
    logic          inv;
  } seq_t;

  function automatic seq_t prog(int i);
    seq_t s;
    s = '0;
    case (i)
      2:  s.mode = 3'd2;
      12: begin s.mode = 3'd3; s.addr = 10'd20; s.sel = 2'd1; end
      13: begin s.mode = 3'd3; s.addr = 10'd20; s.sel = 2'd1; s.inv = 1'b1; end
      14: begin s.mode = 3'd1; s.addr = 10'd22; end
      17: s.mode = 3'd7;
      18: s.mode = 3'd6;
      24: begin s.mode = 3'd4; s.addr = 10'd40; end
      25: begin s.mode = 3'd1; s.addr = 10'd30; end
      30, 31, 32, 33, 34: begin s.mode = 3'd4; s.addr = SB'(i + 1); end
      35: begin s.mode = 3'd1; s.addr = 10'd45; end
      40, 45: s.mode = 3'd5;
      46: begin s.mode = 3'd3; s.addr = 10'd2; s.sel = 2'd3; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic [CW-1:0] cw_of(int i);
    logic [63:0] h;
    h = 64'(i + 1) * 64'h9E3779B97F4A7C15;
    return h[63:30];
  endfunction

  function automatic logic [SB-1:0] dec_of(int op);
    case (op)
      5:   return 10'd10;
      12, 17, 18, 22, 24, 30, 45, 47: return SB'(op);
      255: return 10'd200;
      default: return SB'((op * 7) % 64);
    endcase
  endfunction

  function automatic logic [NS*MW-1:0] build_rom();
    logic [NS*MW-1:0] img;
    img = '0;
    for (int i = 0; i < NS; i++) img[i*MW +: MW] = {cw_of(i), prog(i)};
    return img;
  endfunction

  function automatic logic [256*SB-1:0] build_dec();
    logic [256*SB-1:0] img;
    img = '0;
    for (int i = 0; i < 256; i++) img[i*SB +: SB] = dec_of(i);
    return img;
  endfunction

  localparam logic [NS*MW-1:0]  ROM_IMG = build_rom();
  localparam logic [256*SB-1:0] DEC_IMG = build_dec();

  logic          clk = 1'b0;
  logic          reset = 1'b1, stall = 1'b0;
  logic [OB-1:0] opcode = '0;
  logic [NC-1:0] cond = '0;
  logic [CW-1:0] ctrl_out;
  logic [SB-1:0] state;
  logic          err;

  always #5 clk = ~clk;

  microsequencer #(
    .CW_WIDTH(CW), .STATE_BITS(SB), .NUM_STATES(NS), .OPC_BITS(OB),
    .NUM_COND(NC), .STACK_DEPTH(SD), .ROM_IMAGE(ROM_IMG), .DECODE_IMAGE(DEC_IMG)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .cond(cond),
    .ctrl_out(ctrl_out), .state(state), .err(err)
  );

  int total = 0, bad = 0;
  int m_state = 0;
  bit m_err = 1'b0;
  int m_stk[$];

  task automatic model_step(bit rst, bit stl, logic [OB-1:0] op, logic [NC-1:0] cn);
    seq_t s;
    int   nx;
    bit   f;
    if (rst) begin
      m_state = 0; m_err = 1'b0; m_stk.delete();
      return;
    end
    if (stl) return;
    s = prog(m_state);
    f = 1'b0;
    nx = 0;
    case (s.mode)
      3'd0: nx = m_state + 1;
      3'd1: nx = int'(s.addr);
      3'd2: nx = int'(dec_of(int'(op)));
      3'd3: nx = (cn[s.sel] ^ s.inv) ? int'(s.addr) : m_state + 1;
`ifdef MICROSEQ_STACK_EN
      3'd4: begin
        nx = int'(s.addr);
        if (m_stk.size() >= SD) f = 1'b1;
        else m_stk.push_back(m_state + 1);
      end
      3'd5: begin
        if (m_stk.size() == 0) begin nx = 0; f = 1'b1; end
        else nx = m_stk.pop_back();
      end
`else
      3'd4: nx = int'(s.addr);
      3'd5: nx = 0;
`endif
      3'd6: nx = 0;
      default: begin nx = 0; f = 1'b1; end
    endcase
    if (nx >= NS) begin nx = 0; f = 1'b1; end
    m_state = nx;
    m_err   = m_err | f;
  endtask

  task automatic check(string tag);
    total++;
    assert (state === SB'(m_state)) else begin
      bad++; $error("FAIL %s state got=%0d want=%0d", tag, state, m_state);
    end
    total++;
    assert (ctrl_out === cw_of(m_state)) else begin
      bad++; $error("FAIL %s ctrl_out got=%h want=%h", tag, ctrl_out, cw_of(m_state));
    end
    total++;
    assert (err === m_err) else begin
      bad++; $error("FAIL %s err got=%0b want=%0b", tag, err, m_err);
    end
  endtask

  task automatic lit(string tag, int ws, bit we);
    total++;
    assert (state === SB'(ws)) else begin
      bad++; $error("FAIL %s state got=%0d want=%0d", tag, state, ws);
    end
    total++;
    assert (err === we) else begin
      bad++; $error("FAIL %s err got=%0b want=%0b", tag, err, we);
    end
  endtask

  task automatic step(bit rst, bit stl, logic [OB-1:0] op, logic [NC-1:0] cn, string tag);
    reset = rst; stall = stl; opcode = op; cond = cn;
    @(posedge clk);
    model_step(rst, stl, op, cn);
    #1 check(tag);
  endtask

  task automatic to2();
    step(1'b1, 1'b0, '0, '0, "rst");
    step(1'b0, 1'b0, '0, '0, "inc");
    step(1'b0, 1'b0, '0, '0, "inc");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at state=%0d", state);
    $fatal(1);
  end

  initial begin
    int ops[10] = '{5, 12, 24, 45, 47, 17, 18, 22, 30, 255};
    logic [OB-1:0] rop;

    step(1'b1, 1'b0, '0, '0, "reset");
    step(1'b1, 1'b0, '0, '0, "reset");
    lit("reset", 0, 1'b0);
    step(1'b0, 1'b0, '0, '0, "inc1");  lit("inc1", 1, 1'b0);
    step(1'b0, 1'b0, '0, '0, "inc2");  lit("inc2", 2, 1'b0);
    step(1'b0, 1'b0, 8'h05, '0, "decode"); lit("decode", 10, 1'b0);
    step(1'b0, 1'b0, '0, '0, "inc11");
    step(1'b0, 1'b0, '0, '0, "inc12"); lit("inc12", 12, 1'b0);
    step(1'b0, 1'b0, '0, 4'b0010, "cond_t"); lit("cond_taken", 20, 1'b0);

    to2();
    step(1'b0, 1'b0, 8'd12, '0, "dec12");
    step(1'b0, 1'b0, '0, 4'b0000, "cond_nt");    lit("cond_not_taken", 13, 1'b0);
    step(1'b0, 1'b0, '0, 4'b0000, "cond_inv_t"); lit("cond_inv_taken", 20, 1'b0);

    to2();
    step(1'b0, 1'b0, 8'd12, '0, "dec12");
    step(1'b0, 1'b0, '0, 4'b0000, "cond_nt");
    step(1'b0, 1'b0, '0, 4'b0010, "cond_inv_nt"); lit("cond_inv_not_taken", 14, 1'b0);
    step(1'b0, 1'b0, '0, '0, "jump");            lit("jump", 22, 1'b0);

    repeat (3) begin
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), "stall");
      lit("stall_hold", 22, 1'b0);
    end
    step(1'b1, 1'b1, '0, '0, "rst_stall"); lit("reset_over_stall", 0, 1'b0);

    step(1'b0, 1'b0, '0, '0, "inc");
    step(1'b0, 1'b0, '0, '0, "inc");
    step(1'b0, 1'b0, 8'd24, '0, "dec24");
    step(1'b0, 1'b0, '0, '0, "call");  lit("call", 40, 1'b0);
    step(1'b0, 1'b0, '0, '0, "ret");
`ifdef MICROSEQ_STACK_EN
    lit("ret", 25, 1'b0);
    step(1'b0, 1'b0, '0, '0, "jmp30");
    repeat (4) step(1'b0, 1'b0, '0, '0, "nest");
    lit("nest4", 34, 1'b0);
    step(1'b0, 1'b0, '0, '0, "ovf");   lit("overflow", 35, 1'b1);
    step(1'b0, 1'b0, '0, '0, "jmp45");
    step(1'b0, 1'b0, '0, '0, "ret34"); lit("ret_after_ovf", 34, 1'b1);
`else
    lit("ret_no_stack", 0, 1'b0);
`endif

    to2();
    step(1'b0, 1'b0, 8'd45, '0, "dec45");
    step(1'b0, 1'b0, '0, '0, "ret_empty");
`ifdef MICROSEQ_STACK_EN
    lit("underflow", 0, 1'b1);
`else
    lit("ret_empty_no_stack", 0, 1'b0);
`endif

    to2();
    step(1'b0, 1'b0, 8'd47, '0, "dec47");
    step(1'b0, 1'b0, '0, '0, "inc48");
    step(1'b0, 1'b0, '0, '0, "inc49"); lit("inc49", 49, 1'b0);
    step(1'b0, 1'b0, '0, '0, "wrap");  lit("wrap", 0, 1'b1);
    step(1'b0, 1'b0, '0, '0, "sticky");
    step(1'b0, 1'b0, '0, '0, "sticky"); lit("sticky", 2, 1'b1);
    step(1'b1, 1'b0, '0, '0, "clr");    lit("err_clear", 0, 1'b0);

    to2();
    step(1'b0, 1'b0, 8'd17, '0, "dec17");
    step(1'b0, 1'b0, '0, '0, "rsvd");   lit("reserved", 0, 1'b1);

    to2();
    step(1'b0, 1'b0, 8'hFF, '0, "bad_dec"); lit("bad_decode", 0, 1'b1);

    step(1'b1, 1'b0, '0, '0, "rst");
    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 1) == 1) ? 8'(ops[$urandom_range(0, 9)]) : 8'($urandom_range(0, 255));
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15, rop,
           4'($urandom_range(0, 15)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
